// File: rtl/cva6_pma_region_table_pkg.sv
// Shared types, default core configuration and reset-table builder for the PMA region table.
package cva6_pma_region_table_pkg;

  localparam int unsigned MaxRegionRules = 4;
  localparam int unsigned MaxEntries     = 16;

  // Static region rules of the core configuration; only used to seed the table at reset.
  typedef struct packed {
    int unsigned                     NrExecuteRegionRules;
    logic [MaxRegionRules-1:0][63:0] ExecuteRegionAddrBase;
    logic [MaxRegionRules-1:0][63:0] ExecuteRegionLength;
    int unsigned                     NrCachedRegionRules;
    logic [MaxRegionRules-1:0][63:0] CachedRegionAddrBase;
    logic [MaxRegionRules-1:0][63:0] CachedRegionLength;
    int unsigned                     NrNonIdempotentRules;
    logic [MaxRegionRules-1:0][63:0] NonIdempotentAddrBase;
    logic [MaxRegionRules-1:0][63:0] NonIdempotentLength;
  } cva6_cfg_t;

  localparam cva6_cfg_t DefaultCfg = '{
    NrExecuteRegionRules:  3,
    ExecuteRegionAddrBase: {64'h0, 64'h8000_0000, 64'h1_0000, 64'h0},
    ExecuteRegionLength:   {64'h0, 64'h4000_0000, 64'h1_0000, 64'h1000},
    NrCachedRegionRules:   1,
    CachedRegionAddrBase:  {64'h0, 64'h0, 64'h0, 64'h8000_0000},
    CachedRegionLength:    {64'h0, 64'h0, 64'h0, 64'h4000_0000},
    NrNonIdempotentRules:  0,
    NonIdempotentAddrBase: '0,
    NonIdempotentLength:   '0
  };

  typedef struct packed {
    logic l;
    logic ni;
    logic c;
    logic x;
  } pma_attr_t;

  typedef struct packed {
    logic [63:0] base;
    logic [63:0] len;
    pma_attr_t   attr;
  } pma_entry_t;

  typedef pma_entry_t [MaxEntries-1:0] pma_table_t;

  // Execute rules first, then cached, then non-idempotent; unused entries stay zero (disabled).
  function automatic pma_table_t pma_reset_table(input cva6_cfg_t cfg, input int unsigned nr_rules);
    pma_table_t  t;
    int unsigned k;
    t = '0;
    k = 0;
    for (int unsigned i = 0; i < MaxRegionRules; i++) begin
      if (i < cfg.NrExecuteRegionRules && k < nr_rules && k < MaxEntries) begin
        t[k].base   = cfg.ExecuteRegionAddrBase[i];
        t[k].len    = cfg.ExecuteRegionLength[i];
        t[k].attr.x = 1'b1;
        k = k + 1;
      end
    end
    for (int unsigned i = 0; i < MaxRegionRules; i++) begin
      if (i < cfg.NrCachedRegionRules && k < nr_rules && k < MaxEntries) begin
        t[k].base   = cfg.CachedRegionAddrBase[i];
        t[k].len    = cfg.CachedRegionLength[i];
        t[k].attr.c = 1'b1;
        k = k + 1;
      end
    end
    for (int unsigned i = 0; i < MaxRegionRules; i++) begin
      if (i < cfg.NrNonIdempotentRules && k < nr_rules && k < MaxEntries) begin
        t[k].base    = cfg.NonIdempotentAddrBase[i];
        t[k].len     = cfg.NonIdempotentLength[i];
        t[k].attr.ni = 1'b1;
        k = k + 1;
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/cva6_pma_match.sv
// Combinational single-entry region matcher: base <= addr < base + len, without forming base + len.
module cva6_pma_match
  import cva6_pma_region_table_pkg::*;
(
  input  logic [63:0] addr_i,
  input  pma_entry_t  entry_i,
  output logic        match_o
);

  logic [63:0] w_offset;
  logic        w_unused_attr;

  assign w_offset      = addr_i - entry_i.base;
  // len == 0 can never satisfy offset < len, so disabled entries fall out naturally.
  assign match_o       = (addr_i >= entry_i.base) && (w_offset < entry_i.len);
  assign w_unused_attr = ^entry_i.attr;

endmodule

// File: rtl/cva6_pma_region_table.sv
// Runtime-programmable, lockable PMA region table with a one-stage pipelined lookup port.
module cva6_pma_region_table
  import cva6_pma_region_table_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg = DefaultCfg,
  parameter int unsigned NrRules = 8,
  parameter int unsigned IdxW    = (NrRules > 1) ? $clog2(NrRules) : 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cfg_we_i,
  input  logic [3:0]  cfg_idx_i,
  input  logic [1:0]  cfg_sel_i,
  input  logic [63:0] cfg_wdata_i,
  output logic [63:0] cfg_rdata_o,
  output logic        cfg_err_o,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [63:0] req_addr_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic        resp_hit_o,
  output logic [2:0]  resp_attr_o
);

  localparam int unsigned NeedRules = CVA6Cfg.NrExecuteRegionRules + CVA6Cfg.NrCachedRegionRules +
                                      CVA6Cfg.NrNonIdempotentRules;
  localparam pma_table_t  ResetTable = pma_reset_table(CVA6Cfg, NrRules);

  if (NrRules < NeedRules) begin : g_too_few_rules
    $error("NrRules is smaller than the number of configured region rules");
  end
  if (NrRules > MaxEntries) begin : g_too_many_rules
    $error("NrRules exceeds the 4-bit configuration index range");
  end

  pma_entry_t         r_table [NrRules];
  logic               r_err;
  logic               r_resp_valid;
  logic               r_resp_hit;
  logic [2:0]         r_resp_attr;

  logic [IdxW-1:0]    w_idx;
  logic               w_idx_ok;
  logic               w_wr_ok;
  logic               w_wr_err;
  logic [63:0]        w_rdata;
  logic [NrRules-1:0] w_match;
  logic               w_hit;
  logic               w_x;
  logic               w_c;
  logic               w_ni;
  logic               w_accept;

  assign w_idx    = cfg_idx_i[IdxW-1:0];
  assign w_idx_ok = 32'(cfg_idx_i) < NrRules;
  // Locked entries, out-of-range indices and the reserved field all reject the write.
  assign w_wr_ok  = cfg_we_i && w_idx_ok && (cfg_sel_i != 2'd3) && !r_table[w_idx].attr.l;
  assign w_wr_err = cfg_we_i && !w_wr_ok;

  // Table state: reload reset contents, otherwise apply accepted field writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NrRules; i++) begin
        r_table[i] <= ResetTable[i];
      end
    end else if (w_wr_ok) begin
      case (cfg_sel_i)
        2'd0:    r_table[w_idx].base <= cfg_wdata_i;
        2'd1:    r_table[w_idx].len  <= cfg_wdata_i;
        2'd2:    r_table[w_idx].attr <= pma_attr_t'(cfg_wdata_i[3:0]);
        default: ;
      endcase
    end
  end

  // Error pulse one cycle after a rejected write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_wr_err;
    end
  end

  // Combinational field readback; illegal index or reserved field reads as zero.
  always_comb begin
    w_rdata = '0;
    if (w_idx_ok) begin
      case (cfg_sel_i)
        2'd0:    w_rdata = r_table[w_idx].base;
        2'd1:    w_rdata = r_table[w_idx].len;
        2'd2:    w_rdata = {60'b0, r_table[w_idx].attr};
        default: w_rdata = '0;
      endcase
    end
  end

  for (genvar g = 0; g < NrRules; g++) begin : g_match
    cva6_pma_match u_match (
      .addr_i  (req_addr_i),
      .entry_i (r_table[g]),
      .match_o (w_match[g])
    );
  end

  // OR-reduce attributes over all matching entries.
  always_comb begin
    w_hit = 1'b0;
    w_x   = 1'b0;
    w_c   = 1'b0;
    w_ni  = 1'b0;
    for (int unsigned i = 0; i < NrRules; i++) begin
      w_hit = w_hit | w_match[i];
      w_x   = w_x   | (w_match[i] & r_table[i].attr.x);
      w_c   = w_c   | (w_match[i] & r_table[i].attr.c);
      w_ni  = w_ni  | (w_match[i] & r_table[i].attr.ni);
    end
  end

  assign req_ready_o = !r_resp_valid || resp_ready_i;
  assign w_accept    = req_valid_i && req_ready_o;

  // Response register: load on accept, drop valid once consumed, hold under backpressure.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_attr  <= 3'b000;
    end else if (w_accept) begin
      r_resp_valid <= 1'b1;
      r_resp_hit   <= w_hit;
      // Non-idempotent space is never cacheable.
      r_resp_attr  <= {w_ni, w_c & ~w_ni, w_x};
    end else if (resp_ready_i) begin
      r_resp_valid <= 1'b0;
    end
  end

  assign cfg_rdata_o  = w_rdata;
  assign cfg_err_o    = r_err;
  assign resp_valid_o = r_resp_valid;
  assign resp_hit_o   = r_resp_hit;
  assign resp_attr_o  = r_resp_attr;

endmodule

// File: tb/tb_cva6_pma_region_table.sv
// Scoreboard bench for the PMA region table: driver pushes model predictions, monitor pops on handshake.
module tb_cva6_pma_region_table;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we_i = 1'b0;
  logic [3:0]  cfg_idx_i = '0;
  logic [1:0]  cfg_sel_i = '0;
  logic [63:0] cfg_wdata_i = '0;
  logic [63:0] cfg_rdata_o;
  logic        cfg_err_o;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [63:0] req_addr_i = '0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b1;
  logic        resp_hit_o;
  logic [2:0]  resp_attr_o;

  cva6_pma_region_table dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cfg_we_i     (cfg_we_i),
    .cfg_idx_i    (cfg_idx_i),
    .cfg_sel_i    (cfg_sel_i),
    .cfg_wdata_i  (cfg_wdata_i),
    .cfg_rdata_o  (cfg_rdata_o),
    .cfg_err_o    (cfg_err_o),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_hit_o   (resp_hit_o),
    .resp_attr_o  (resp_attr_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference table: 8 entries, attr nibble = {L, NI, C, X}.
  logic [63:0] m_base [8];
  logic [63:0] m_len  [8];
  logic [3:0]  m_attr [8];

  logic [3:0]  exp_q [$];      // {hit, NI, C, X} per accepted lookup
  bit          pend_valid = 0;
  logic [3:0]  pend_exp = '0;
  bit          prev_accept = 0;
  bit          exp_err = 0;

  logic [63:0] addr_pool [12] = '{64'h0, 64'hFFF, 64'h1000, 64'h1_0000, 64'h1_FFFF, 64'h2_0000,
                                  64'h8000_0000, 64'h8000_0800, 64'h8000_1000, 64'hBFFF_FFFF,
                                  64'hC000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
  logic [63:0] len_pool [6]  = '{64'h0, 64'h1, 64'h1000, 64'h4000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                                 64'h800};

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      m_base[i] = '0;
      m_len[i]  = '0;
      m_attr[i] = '0;
    end
    m_base[0] = 64'h0;         m_len[0] = 64'h1000;      m_attr[0] = 4'b0001;
    m_base[1] = 64'h1_0000;    m_len[1] = 64'h1_0000;    m_attr[1] = 4'b0001;
    m_base[2] = 64'h8000_0000; m_len[2] = 64'h4000_0000; m_attr[2] = 4'b0001;
    m_base[3] = 64'h8000_0000; m_len[3] = 64'h4000_0000; m_attr[3] = 4'b0010;
  endfunction

  // Region test done in 65-bit arithmetic so base + len cannot wrap.
  function automatic logic [3:0] model_lookup(input logic [63:0] addr);
    logic [64:0] lo, hi, a;
    bit hit, ni, c, x;
    hit = 0; ni = 0; c = 0; x = 0;
    a = {1'b0, addr};
    for (int i = 0; i < 8; i++) begin
      lo = {1'b0, m_base[i]};
      hi = lo + {1'b0, m_len[i]};
      if (a >= lo && a < hi) begin
        hit = 1;
        x   = x  | m_attr[i][0];
        c   = c  | m_attr[i][1];
        ni  = ni | m_attr[i][2];
      end
    end
    return {hit, ni, c & !ni, x};
  endfunction

  function automatic logic [63:0] model_read(input int unsigned idx, input int unsigned sel);
    if (idx >= 8) return 64'h0;
    case (sel)
      0: return m_base[idx];
      1: return m_len[idx];
      2: return {60'h0, m_attr[idx]};
      default: return 64'h0;
    endcase
  endfunction

  // Returns 1 when the write is rejected.
  function automatic bit model_write(input int unsigned idx, input int unsigned sel,
                                     input logic [63:0] d);
    if (idx >= 8) return 1;
    if (sel == 3) return 1;
    if (m_attr[idx][3]) return 1;
    case (sel)
      0: m_base[idx] = d;
      1: m_len[idx]  = d;
      default: m_attr[idx] = d[3:0];
    endcase
    return 0;
  endfunction

  task automatic flush_pend();
    if (pend_valid) begin
      exp_q.push_back(pend_exp);
      pend_valid = 0;
    end
  endtask

  // One cycle of stimulus; predictions use the table as it stands before this cycle's write.
  task automatic step(input bit we, input logic [3:0] idx, input logic [1:0] sel,
                      input logic [63:0] wd, input bit rv, input logic [63:0] ra, input bit rr);
    bit exp_ready;
    @(negedge clk);
    flush_pend();
    chk("cfg_err", {63'h0, cfg_err_o}, {63'h0, exp_err});
    if (prev_accept) chk("latency", {63'h0, resp_valid_o}, 64'h1);
    cfg_we_i     = we;
    cfg_idx_i    = idx;
    cfg_sel_i    = sel;
    cfg_wdata_i  = wd;
    req_valid_i  = rv;
    req_addr_i   = ra;
    resp_ready_i = rr;
    #1;
    exp_ready = (exp_q.size() == 0) || rr;
    chk("req_ready", {63'h0, req_ready_o}, {63'h0, exp_ready});
    chk("cfg_rdata", cfg_rdata_o, model_read(idx, sel));
    prev_accept = rv && exp_ready;
    if (prev_accept) begin
      pend_valid = 1;
      pend_exp   = model_lookup(ra);
    end
    exp_err = we ? model_write(idx, sel, wd) : 1'b0;
  endtask

  task automatic apply_reset(input bit mid);
    if (mid) begin
      @(negedge clk);
      flush_pend();
      #3;
      chk("pending_before_reset", {63'h0, resp_valid_o}, 64'h1);
    end
    rst_n = 1'b0;
    #1;
    chk("reset_outputs", {57'h0, resp_valid_o, req_ready_o, cfg_err_o, resp_hit_o, resp_attr_o},
        64'b0100000);
    exp_q.delete();
    pend_valid   = 0;
    prev_accept  = 0;
    exp_err      = 0;
    model_reset();
    cfg_we_i     = 1'b0;
    req_valid_i  = 1'b0;
    resp_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: checks valid against outstanding predictions and pops on each consumed response.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        chk("resp_valid", {63'h0, resp_valid_o}, {63'h0, (exp_q.size() != 0)});
        if (resp_valid_o && exp_q.size() != 0) begin
          chk("resp_hit_attr", {60'h0, resp_hit_o, resp_attr_o}, {60'h0, exp_q[0]});
          if (resp_ready_i) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  ridx;
    logic [1:0]  rsel;
    logic [63:0] rwd;
    logic [63:0] raddr;
    int          drain;

    model_reset();
    apply_reset(0);

    // Reset readback including an illegal index and the reserved field.
    for (int i = 0; i < 10; i++)
      for (int s = 0; s < 4; s++)
        step(0, 4'(i), 2'(s), 64'h0, 0, 64'h0, 1);

    // Directed lookups: DRAM hit, exclusive upper bound, small execute region.
    step(0, 0, 0, 0, 1, 64'h8000_1000, 1);
    step(0, 0, 0, 0, 1, 64'hBFFF_FFFF, 1);
    step(0, 0, 0, 0, 1, 64'hC000_0000, 1);
    step(0, 0, 0, 0, 1, 64'h0FFF, 1);
    step(0, 0, 0, 0, 1, 64'h1000, 1);
    step(0, 0, 0, 0, 0, 64'h0, 1);

    // Program entry 5 as NI; the attr write shares a cycle with a lookup that must see old contents.
    step(1, 4'd5, 2'd0, 64'h8000_0000, 0, 64'h0, 1);
    step(1, 4'd5, 2'd1, 64'h1000, 0, 64'h0, 1);
    step(1, 4'd5, 2'd2, 64'h4, 1, 64'h8000_0800, 1);
    step(0, 4'd5, 2'd2, 64'h0, 1, 64'h8000_0800, 1);
    step(0, 0, 0, 0, 0, 64'h0, 1);

    // Lock entry 5, then try to rewrite it and an out-of-range index.
    step(1, 4'd5, 2'd2, 64'hC, 0, 64'h0, 1);
    step(1, 4'd5, 2'd0, 64'h0, 0, 64'h0, 1);
    step(0, 4'd5, 2'd0, 64'h0, 0, 64'h0, 1);
    step(0, 4'd5, 2'd0, 64'h0, 0, 64'h0, 1);
    step(1, 4'd9, 2'd0, 64'h1234, 0, 64'h0, 1);
    step(1, 4'd2, 2'd3, 64'h1234, 0, 64'h0, 1);
    step(0, 4'd9, 2'd0, 64'h0, 0, 64'h0, 1);
    step(0, 4'd5, 2'd2, 64'h0, 0, 64'h0, 1);

    // Backpressure: one accepted, held three cycles, then drains one per cycle.
    step(0, 0, 0, 0, 1, 64'h8000_0800, 0);
    step(0, 0, 0, 0, 1, 64'h1_8000, 0);
    step(0, 0, 0, 0, 1, 64'h1_8000, 0);
    step(0, 0, 0, 0, 1, 64'h1_8000, 0);
    step(0, 0, 0, 0, 1, 64'h1_8000, 1);
    step(0, 0, 0, 0, 1, 64'hC000_0000, 1);
    step(0, 0, 0, 0, 1, 64'h0, 1);
    step(0, 0, 0, 0, 0, 64'h0, 1);

    // Reset with a response pending; entry 5 must be writable again afterwards.
    step(0, 0, 0, 0, 1, 64'h8000_0000, 0);
    apply_reset(1);
    step(1, 4'd5, 2'd0, 64'h1234_5000, 0, 64'h0, 1);
    step(1, 4'd5, 2'd1, 64'h100, 0, 64'h0, 1);
    step(0, 4'd5, 2'd0, 64'h0, 1, 64'h1234_50FF, 1);
    step(0, 4'd5, 2'd1, 64'h0, 1, 64'h1234_5100, 1);

    // Randomised traffic: writes, locks, reads, lookups and backpressure interleaved.
    for (int n = 0; n < 2000; n++) begin
      ridx = ($urandom_range(0, 15) == 0) ? 4'(15) : 4'($urandom_range(0, 9));
      rsel = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0:       rwd = addr_pool[$urandom_range(0, 11)];
        1:       rwd = len_pool[$urandom_range(0, 5)];
        default: rwd = {$urandom, $urandom};
      endcase
      if (rsel == 2'd2 && $urandom_range(0, 7) != 0) rwd[3] = 1'b0;
      raddr = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom}
                                          : addr_pool[$urandom_range(0, 11)];
      step(($urandom_range(0, 3) == 0), ridx, rsel, rwd, $urandom_range(0, 1) == 1, raddr,
           $urandom_range(0, 3) != 0);
    end

    // Drain remaining responses with a bounded wait.
    drain = 0;
    while ((exp_q.size() != 0 || pend_valid) && drain < 20) begin
      step(0, 0, 0, 0, 0, 64'h0, 1);
      drain++;
    end
    step(0, 0, 0, 0, 0, 64'h0, 1);
    chk("drain_empty", 64'(exp_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
